// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and constants: FSM states, operation
// encoding, the data-segment base address and a counter sizing helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DATA_BASE = 1024;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Bits needed to hold a wait count; never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    if (wait_cycles < 1) begin
      return 1;
    end else begin
      return $clog2(wait_cycles + 1);
    end
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Load/decrement wait-state counter; done is high while the count is zero.
module wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] count_r;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = (count_r == '0);

endmodule

// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two 16-bit asynchronous SRAM accesses,
// holding ready low (pipeline freeze) until the second half completes.
module sram_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_ADDR_W = 18,
  parameter int DATA_BASE   = mem_pkg::DATA_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_o,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  import mem_pkg::*;

  localparam int IDX_W = SRAM_ADDR_W - 1;
  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  state_t             state_r;
  state_t             state_s;
  logic               op_r;
  logic [31:0]        read_data_r;
  logic [31:0]        offset_s;
  logic [IDX_W-1:0]   idx_s;
  logic               req_s;
  logic               cnt_load_s;
  logic               cnt_dec_s;
  logic               cnt_done_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               unused_s;

  // Word index relative to the data segment; out-of-range addresses wrap.
  assign offset_s = address - 32'(DATA_BASE);
  assign idx_s    = offset_s[IDX_W+1:2];
  assign req_s    = rd_en | wr_en;
  assign unused_s = ^{offset_s[31:IDX_W+2], offset_s[1:0], cnt_s};

  wait_counter #(
    .W (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .count    (cnt_s),
    .done     (cnt_done_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operation latch: taken only when a request is accepted in IDLE; store wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r <= OP_RD;
    end else if ((state_r == IDLE) && req_s) begin
      op_r <= wr_en ? OP_WR : OP_RD;
    end else begin
      op_r <= op_r;
    end
  end

  // Load data capture on the last cycle of each half-word access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_r <= 32'h0000_0000;
    end else if ((op_r == OP_RD) && cnt_done_s && (state_r == LOW)) begin
      read_data_r[15:0] <= sram_dq_i;
    end else if ((op_r == OP_RD) && cnt_done_s && (state_r == HIGH)) begin
      read_data_r[31:16] <= sram_dq_i;
    end else begin
      read_data_r <= read_data_r;
    end
  end

  assign read_data = read_data_r;

  // Next-state and wait-counter control.
  always_comb begin
    state_s    = state_r;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s    = LOW;
          cnt_load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOW: begin
        if (cnt_done_s) begin
          state_s    = HIGH;
          cnt_load_s = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_done_s) begin
          state_s = DONE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Ready and SRAM pin decode from the current state; idle pins are quiet.
  always_comb begin
    ready      = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = 16'h0000;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state_r)
      IDLE: begin
        ready = ~req_s;
      end
      LOW, HIGH: begin
        ready     = 1'b0;
        sram_addr = {idx_s, (state_r == HIGH)};
        if (op_r == OP_WR) begin
          sram_we_n  = 1'b0;
          sram_dq_oe = 1'b1;
          sram_dq_o  = (state_r == HIGH) ? write_data[31:16] : write_data[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench: two controllers (WAIT_CYCLES=1 and 0) on behavioural
// SRAM models, driven from a vector table plus a mid-access reset sequence.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_n;
  logic        rd_en [2];
  logic        wr_en [2];
  logic [31:0] address [2];
  logic [31:0] write_data [2];
  wire  [31:0] read_data [2];
  wire         ready [2];
  wire  [17:0] sram_addr [2];
  wire  [15:0] dq_o [2];
  wire  [15:0] dq_i [2];
  wire         dq_oe [2];
  wire         we_n [2];
  wire         oe_n [2];
  logic [15:0] mem [2][16];

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    int          d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_o(dq_o[0]),
    .sram_dq_i(dq_i[0]), .sram_dq_oe(dq_oe[0]), .sram_we_n(we_n[0]),
    .sram_oe_n(oe_n[0])
  );

  sram_controller #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_o(dq_o[1]),
    .sram_dq_i(dq_i[1]), .sram_dq_oe(dq_oe[1]), .sram_we_n(we_n[1]),
    .sram_oe_n(oe_n[1])
  );

  function automatic logic [15:0] pat(input int i);
    case (i)
      2:       return 16'h5678;
      3:       return 16'h1234;
      default: return 16'hA500 | 16'(i);
    endcase
  endfunction

  // SRAM model: 16 words per device (low address bits only), written while we_n is low.
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 16; i++)
          mem[d][i] <= pat(i);
    end else begin
      for (int d = 0; d < 2; d++)
        if (!we_n[d]) mem[d][sram_addr[d][3:0]] <= dq_o[d];
    end
  end

  assign dq_i[0] = mem[0][sram_addr[0][3:0]];
  assign dq_i[1] = mem[1][sram_addr[1][3:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int w;
    int lat;
    bit hi;
    logic [31:0] off;
    logic [16:0] idx;
    w = (d == 0) ? 1 : 0;
    lat = 99;
    off = addr - 32'd1024;
    idx = off[18:2];
    exp_q.push_back(exp_rdata);
    @(negedge clk);
    rd_en[d] = rd; wr_en[d] = wr; address[d] = addr; write_data[d] = wdata;
    #1 chk("ready_req_idle", 32'(ready[d]), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready[d]) begin
        lat = k;
        break;
      end
      hi = (k > w + 1);
      chk("sram_addr", 32'(sram_addr[d]), 32'({idx, hi}));
      chk("we_n", 32'(we_n[d]), wr ? 32'd0 : 32'd1);
      chk("oe_n", 32'(oe_n[d]), wr ? 32'd1 : 32'd0);
      chk("dq_oe", 32'(dq_oe[d]), wr ? 32'd1 : 32'd0);
      chk("dq_o", 32'(dq_o[d]), wr ? 32'(hi ? wdata[31:16] : wdata[15:0]) : 32'd0);
    end
    chk("done_latency", 32'(lat), 32'(2 * (w + 1) + 1));
    chk("read_data", read_data[d], exp_q.pop_front());
    chk("done_we_n", 32'(we_n[d]), 32'd1);
    chk("done_addr", 32'(sram_addr[d]), 32'd0);
    @(posedge clk);
    #1;
    rd_en[d] = 1'b0; wr_en[d] = 1'b0;
    #1 chk("idle_after_done", 32'(ready[d]), 32'd1);
    if (wr) begin
      chk("mem_lo", 32'(mem[d][{idx[2:0], 1'b0}]), 32'(wdata[15:0]));
      chk("mem_hi", 32'(mem[d][{idx[2:0], 1'b1}]), 32'(wdata[31:16]));
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{0, 1'b1, 1'b0, 32'd1028, 32'h00000000, 32'h12345678};
    vecs[2]  = '{0, 1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h12345678};
    vecs[3]  = '{0, 1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hCAFEF00D};
    vecs[4]  = '{0, 1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF};
    vecs[5]  = '{0, 1'b1, 1'b0, 32'd1020, 32'h00000000, 32'hA50FA50E};
    vecs[6]  = '{0, 1'b1, 1'b0, 32'd1028, 32'h00000000, 32'h12345678};
    vecs[7]  = '{1, 1'b1, 1'b0, 32'd1028, 32'h00000000, 32'h12345678};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hA501A500};
    vecs[9]  = '{1, 1'b0, 1'b1, 32'd1036, 32'h0BADC0DE, 32'hA501A500};
    vecs[10] = '{1, 1'b1, 1'b0, 32'd1036, 32'h00000000, 32'h0BADC0DE};

    rst = 1'b0;
    init_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b0; wr_en[d] = 1'b0; address[d] = 32'd0; write_data[d] = 32'd0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(ready[d]), 32'd1);
      chk("rst_read_data", read_data[d], 32'd0);
      chk("rst_sram_addr", 32'(sram_addr[d]), 32'd0);
      chk("rst_dq_o", 32'(dq_o[d]), 32'd0);
      chk("rst_strobes", 32'({dq_oe[d], we_n[d], oe_n[d]}), 32'b011);
    end
    @(negedge clk);
    rst = 1'b1;
    init_n = 1'b1;

    for (int i = 0; i < 6; i++)
      access(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Reset during the HIGH half of a store to 1040 (SRAM words 8/9).
    @(negedge clk);
    wr_en[0] = 1'b1; address[0] = 32'd1040; write_data[0] = 32'h11112222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_high_addr", 32'(sram_addr[0]), 32'd9);
    chk("pre_rst_we_n", 32'(we_n[0]), 32'd0);
    rst = 1'b0;
    wr_en[0] = 1'b0;
    #1;
    chk("rst_mid_we_n", 32'(we_n[0]), 32'd1);
    chk("rst_mid_dq_oe", 32'(dq_oe[0]), 32'd0);
    chk("rst_mid_ready", 32'(ready[0]), 32'd1);
    chk("rst_mid_read_data", read_data[0], 32'd0);
    chk("rst_mid_addr", 32'(sram_addr[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_lo_written", 32'(mem[0][8]), 32'h2222);
    chk("rst_no_hi_write", 32'(mem[0][9]), 32'(pat(9)));

    for (int i = 6; i < 11; i++)
      access(vecs[i].d, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
